// File: rtl/rdata_return_pkg.sv
// ---------------------------------------------------------------------------
// rdata_return_pkg
// Shared constants and helpers for the read-data return path.
//   RD_LATENCY_MAX : upper bound on the RAM read latency the return path
//                    tracks (sizes the in-flight credit arithmetic).
//   ptr_width()    : log2 of a power-of-two FIFO depth (pointer width).
// ---------------------------------------------------------------------------
package rdata_return_pkg;

    localparam int RD_LATENCY_MAX = 8;

    // Smallest w with 2**w >= depth; exact log2 for power-of-two depths.
    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rdata_fifo.sv
// ---------------------------------------------------------------------------
// rdata_fifo
// Return-data FIFO: storage, read/write pointers and occupancy count.
// Overflow is prevented upstream by the credit logic, and pop is only
// issued while non-empty, so neither condition is checked here.
// Ports:
//   pll_clock : clock (rising edge)
//   reset_n   : asynchronous active-low reset; clears storage, pointers, count
//   push      : write din at the tail
//   pop       : advance the head
//   din       : write data
//   dout      : head entry (combinational from storage)
//   count     : number of stored entries (log2(DEPTH)+1 bits)
// ---------------------------------------------------------------------------
module rdata_fifo
    import rdata_return_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic             pll_clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    // Storage is reset too so the head reads zero out of reset.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leave the count unchanged.
            if (push && !pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!push && pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/rdata_return.sv
// ---------------------------------------------------------------------------
// rdata_return
// Read-data return path. Tracks accepted read requests through the fixed
// RAM read latency, captures the returned word into a small FIFO and hands
// it to the consumer with a valid/ready handshake. A credit scheme (buffered
// plus in-flight words against DEPTH) drives busy so no returned word is
// ever lost.
// Optional feature macro: RDATA_RETURN_ADDR_ECHO_EN -- carries the request
// address alongside the data and presents it on addr_out.
// Ports:
//   pll_clock  : clock (rising edge)
//   reset_n    : asynchronous active-low reset
//   e_in       : read request strobe
//   addr_in    : request address (used only with the echo feature)
//   busy       : new request cannot be accepted
//   ram_rdata  : RAM read data, valid RD_LATENCY cycles after an accept
//   rdata_out  : FIFO head data
//   rvalid_out : FIFO non-empty
//   rready_in  : consumer ready
//   addr_out   : address matching rdata_out (echo feature only)
//   drop_err   : sticky, set when e_in arrives while busy
// ---------------------------------------------------------------------------
module rdata_return
    import rdata_return_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  pll_clock,
    input  logic                  reset_n,
    input  logic                  e_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  rvalid_out,
    input  logic                  rready_in,
`ifdef RDATA_RETURN_ADDR_ECHO_EN
    output logic [ADDR_WIDTH-1:0] addr_out,
`endif
    output logic                  drop_err
);

    localparam int PW    = ptr_width(DEPTH);
    // Wide enough for DEPTH buffered plus RD_LATENCY_MAX in-flight words.
    localparam int SUM_W = PW + 5;
`ifdef RDATA_RETURN_ADDR_ECHO_EN
    localparam int FW    = DATA_WIDTH + ADDR_WIDTH;
`else
    localparam int FW    = DATA_WIDTH;
`endif

    logic [RD_LATENCY-1:0] r_vld_pipe;
    logic                  r_drop_err;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [PW:0]           w_count;
    logic [SUM_W-1:0]      w_credit_used;
    logic [FW-1:0]         w_fifo_din;
    logic [FW-1:0]         w_fifo_dout;

    assign w_accept = e_in & ~busy;
    assign w_push   = r_vld_pipe[RD_LATENCY-1];
    assign w_pop    = rvalid_out & rready_in;

    // Credits in use = buffered words + requests still in the RAM pipeline.
    // Built only from registers, so a same-cycle pop frees its credit one
    // cycle later.
    always_comb begin
        w_credit_used = SUM_W'(w_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_credit_used = w_credit_used + SUM_W'(r_vld_pipe[i]);
        end
    end

    assign busy = (w_credit_used >= SUM_W'(DEPTH));

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
            if (e_in && busy) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign drop_err = r_drop_err;

`ifdef RDATA_RETURN_ADDR_ECHO_EN
    // Address shadow of the valid pipeline; contents only matter where the
    // matching valid bit is set, so it needs no reset.
    logic [ADDR_WIDTH-1:0] r_addr_pipe [RD_LATENCY];

    always_ff @(posedge pll_clock) begin
        r_addr_pipe[0] <= addr_in;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_addr_pipe[i] <= r_addr_pipe[i-1];
        end
    end

    assign w_fifo_din = {r_addr_pipe[RD_LATENCY-1], ram_rdata};
    assign addr_out   = w_fifo_dout[DATA_WIDTH +: ADDR_WIDTH];
`else
    logic w_unused_addr;
    assign w_unused_addr = ^addr_in;
    assign w_fifo_din    = ram_rdata;
`endif

    rdata_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_fifo_din),
        .dout      (w_fifo_dout),
        .count     (w_count)
    );

    assign rdata_out  = w_fifo_dout[DATA_WIDTH-1:0];
    assign rvalid_out = (w_count != '0);

endmodule

// File: tb/tb_rdata_return.sv
// ---------------------------------------------------------------------------
// tb_rdata_return
// Self-checking bench for rdata_return (RD_LATENCY=2, DEPTH=4). A queue
// based model tracks outstanding requests by due cycle and buffered words
// by value; every cycle the DUT outputs are compared against it, and a few
// hand-derived literal expectations pin the model to the documented timing.
// ---------------------------------------------------------------------------
module tb_rdata_return;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          e_in = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          busy;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] rdata_out;
    logic          rvalid_out;
    logic          rready_in = 1'b0;
    logic          drop_err;
`ifdef RDATA_RETURN_ADDR_ECHO_EN
    logic [AW-1:0] addr_out;
`endif

    rdata_return #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (L),
        .DEPTH      (D)
    ) dut (
        .pll_clock  (clk),
        .reset_n    (reset_n),
        .e_in       (e_in),
        .addr_in    (addr_in),
        .busy       (busy),
        .ram_rdata  (ram_rdata),
        .rdata_out  (rdata_out),
        .rvalid_out (rvalid_out),
        .rready_in  (rready_in),
`ifdef RDATA_RETURN_ADDR_ECHO_EN
        .addr_out   (addr_out),
`endif
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } ent_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
    } pend_t;

    ent_t          fifo_q[$];
    pend_t         pend_q[$];
    logic [DW-1:0] dut_pops[$];
    logic [AW-1:0] dut_pop_addr[$];
    logic          drop_m = 1'b0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    function automatic logic model_busy();
        return (fifo_q.size() + pend_q.size()) >= D;
    endfunction

    task automatic check_model();
        chk("rvalid", {31'b0, rvalid_out}, {31'b0, fifo_q.size() != 0});
        if (fifo_q.size() != 0) begin
            chk("rdata", rdata_out, fifo_q[0].d);
`ifdef RDATA_RETURN_ADDR_ECHO_EN
            chk("addr_out", {21'b0, addr_out}, {21'b0, fifo_q[0].a});
`endif
        end
        chk("busy", {31'b0, busy}, {31'b0, model_busy()});
        chk("drop_err", {31'b0, drop_err}, {31'b0, drop_m});
    endtask

    // Apply inputs, advance the model across the coming edge, then compare.
    task automatic step(input logic e, input logic rdy, input logic [DW-1:0] rd, input logic [AW-1:0] a);
        logic bsy;
        e_in = e; rready_in = rdy; ram_rdata = rd; addr_in = a;
        bsy = model_busy();
        if (rvalid_out && rdy) begin
            dut_pops.push_back(rdata_out);
`ifdef RDATA_RETURN_ADDR_ECHO_EN
            dut_pop_addr.push_back(addr_out);
`endif
        end
        if (e && bsy) drop_m = 1'b1;
        if (fifo_q.size() != 0 && rdy) void'(fifo_q.pop_front());
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
            ent_t en;
            en.d = rd; en.a = pend_q[0].a;
            fifo_q.push_back(en);
            void'(pend_q.pop_front());
        end
        if (e && !bsy) begin
            pend_t p;
            p.due = cyc + L; p.a = a;
            pend_q.push_back(p);
        end
        cyc++;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_rvalid", {31'b0, rvalid_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_drop", {31'b0, drop_err}, 32'd0);
        fifo_q.delete(); pend_q.delete(); drop_m = 1'b0;
        e_in = 1'b0; rready_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            ram_rdata = $urandom();
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic any_busy;
        #2;
        apply_reset();

        // Single request, returned word 0xA5A5A5A5 after two cycles.
        step(1'b1, 1'b0, 32'h0, 11'h7FF);
        step(1'b0, 1'b0, 32'h0, 11'h0);
        chk("lat_not_yet", {31'b0, rvalid_out}, 32'd0);
        step(1'b0, 1'b0, 32'hA5A5A5A5, 11'h0);
        chk("lat_valid", {31'b0, rvalid_out}, 32'd1);
        chk("lat_data", rdata_out, 32'hA5A5A5A5);
        step(1'b0, 1'b1, 32'h0, 11'h0);
        chk("lat_popped", {31'b0, rvalid_out}, 32'd0);

        // Fill all credits, then overflow request.
        dut_pops.delete(); dut_pop_addr.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h100 + i, 11'(i));
        chk("fill_busy", {31'b0, busy}, 32'd1);
        chk("fill_nodrop", {31'b0, drop_err}, 32'd0);
        step(1'b1, 1'b0, 32'h104, 11'h0);
        chk("drop_set", {31'b0, drop_err}, 32'd1);
        step(1'b0, 1'b0, 32'h105, 11'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'hDEAD0000 + i, 11'h0);
        chk("drain_cnt", dut_pops.size(), 32'd4);
        if (dut_pops.size() == 4) begin
            chk("drain_w0", dut_pops[0], 32'h102);
            chk("drain_w3", dut_pops[3], 32'h105);
        end
        chk("drop_sticky", {31'b0, drop_err}, 32'd1);
        apply_reset();

        // Streaming 16 requests with consumer always ready.
        dut_pops.delete(); dut_pop_addr.delete();
        any_busy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            step(i < 16, 1'b1, 32'(i), 11'(i));
            if (busy) any_busy = 1'b1;
        end
        chk("stream_busy", {31'b0, any_busy}, 32'd0);
        chk("stream_cnt", dut_pops.size(), 32'd16);
        if (dut_pops.size() == 16) begin
            chk("stream_first", dut_pops[0], 32'd2);
            chk("stream_last", dut_pops[15], 32'd17);
        end
        chk("stream_drop", {31'b0, drop_err}, 32'd0);

        // Address echo at boundary addresses.
        dut_pops.delete(); dut_pop_addr.delete();
        step(1'b1, 1'b0, 32'h0, 11'h7FF);
        step(1'b1, 1'b0, 32'h0, 11'h000);
        step(1'b1, 1'b0, 32'h11, 11'h123);
        step(1'b0, 1'b0, 32'h22, 11'h0);
        step(1'b0, 1'b0, 32'h33, 11'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 11'h0);
        chk("echo_cnt", dut_pops.size(), 32'd3);
`ifdef RDATA_RETURN_ADDR_ECHO_EN
        if (dut_pop_addr.size() == 3) begin
            chk("echo_a0", {21'b0, dut_pop_addr[0]}, 32'h7FF);
            chk("echo_a1", {21'b0, dut_pop_addr[1]}, 32'h000);
            chk("echo_a2", {21'b0, dut_pop_addr[2]}, 32'h123);
        end
`endif

        // Reset with two requests in flight and one buffered.
        step(1'b1, 1'b0, 32'h0, 11'h0);
        step(1'b1, 1'b0, 32'h0, 11'h0);
        step(1'b1, 1'b0, 32'h77, 11'h0);
        chk("pre_rst_valid", {31'b0, rvalid_out}, 32'd1);
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 32'hFFFFFFFF : 32'h0, 11'h0);
        chk("post_rst_empty", {31'b0, rvalid_out}, 32'd0);

        // Randomized traffic, including a mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) apply_reset();
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom(), 11'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
